vga_pattern_gen: RTL and testbench
==================================

// Module: vga_pattern_gen
// PURPOSE
//  Parametrised test-pattern generator driven by vga_sync (display_en, x_pos, y_pos,
//  h_sync, v_sync). Four modes: quadrants, colour bars, checkerboard, bouncing box.
//  Registered 2-stage pixel pipeline; syncs delayed to match; mode switch only at frame start.
//  Sits between vga_sync and the board's RGB/sync pins.
// PARAMETERS
//  H_ACTIVE   800  visible pixels per line
//  V_ACTIVE   600  visible lines per frame
//  POS_W      11   width of x_pos/y_pos
//  R_W/G_W/B_W 3/2/3 colour channel widths
//  CHECK_LOG2 5    checker square = 2**CHECK_LOG2 pixels
//  BOX_SIZE   64   bouncing box edge, pixels (< H_ACTIVE, V_ACTIVE)
//  STEP       2    box move per frame, pixels per axis
// PORTS
//  clk         in   1      pixel clock
//  rst         in   1      synchronous, active-high reset
//  display_en  in   1      active-video flag from vga_sync
//  x_pos       in   POS_W  pixel column, valid when display_en
//  y_pos       in   POS_W  pixel line, valid when display_en
//  h_sync_in   in   1      horizontal sync from vga_sync
//  v_sync_in   in   1      vertical sync from vga_sync
//  mode_sel    in   2      requested mode, sampled at frame start
//  h_sync      out  1      h_sync_in delayed 2 cycles
//  v_sync      out  1      v_sync_in delayed 2 cycles
//  red/green/blue out R_W/G_W/B_W  pixel colour
//  frame_tick  out  1      1-cycle pulse, aligned with output of pixel (0,0)
// BEHAVIOUR
//  Reset: all outputs 0; active mode 0; box_x=box_y=0; direction +x,+y.
//  Latency: 2 cycles, in->out, for colour, syncs, frame_tick. Stage1: compute colour
//   from registered inputs; stage2: output regs. No combinational in->out path.
//  Blanking (display_en=0 at input): colour 0 (never Z).
//  Frame start = display_en && x_pos==0 && y_pos==0; latch mode_sel into active mode
//   that cycle; that pixel already uses the new mode.
//  Mode 0 quadrants: x<H/2,y<V/2 red; x>=H/2,y<V/2 blue; x<H/2,y>=V/2 green;
//   else white. Midlines belong to right/bottom quadrant (no black seam).
//  Mode 1 bars: 8 equal bars, BAR_W=H_ACTIVE/8 (localparam), left->right white, yellow,
//   cyan, green, magenta, red, blue, black. Threshold compares; no divider. Remainder px black.
//  Mode 2 checker: x[CHECK_LOG2]^y[CHECK_LOG2] ? white : black.
//  Mode 3 box: white where box_x<=x<box_x+BOX_SIZE and same on y; else blue.
//  Box update: once per frame, on last active pixel (x=H_ACTIVE-1, y=V_ACTIVE-1),
//   all modes. Per axis: next=pos±STEP; if next would exceed limit
//   (H_ACTIVE-BOX_SIZE / V_ACTIVE-BOX_SIZE) or go below 0, clamp to limit/0 and flip dir.
//   Use POS_W+1 bit signed intermediate to avoid wrap.
//  Reset mid-frame: everything returns to reset values next cycle; mode 0 until next frame start.
//  mode_sel changes mid-frame: ignored until next frame start.
//  White = all ones in every channel; "red" = R all ones, G,B zero; etc.
// STRUCTURE
//  Package vga_pkg: mode encodings (QUAD=0, BARS=1, CHECK=2, BOX=3), colour constants
//   (white..black) as {R,G,B} structs/localparams, default 800x600 timing constants.
//  Sub-module vga_box_mover: box_x/box_y/direction registers and bounce logic;
//   inputs clk, rst, frame_end; outputs box_x, box_y.
// TESTING
//  1 Reset, mode_sel=0, sweep frame -> (0,0) red, (400,0) blue, (399,300) green,
//    (400,300) white, 2 cycles after x/y applied; blanking -> 0.
//  2 mode_sel=1 -> x=0 white, x=100 yellow, x=650 blue, x=799 black.
//  3 mode_sel=2 -> (0,0) black, (32,0) white, (32,32) black.
//  4 mode_sel changed 0->2 at (10,10) -> rest of frame quadrants; next frame checker.
//  5 mode 3, run 368 frames -> box_x clamps 736, dir flips, next frame 734; box_y
//    clamps 536 at frame 268; frame_tick once per frame.
//  6 rst asserted mid-line -> next cycle all outputs 0, box at 0, mode 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator: mode encodings,
// on/off colour masks and default 800x600 timing constants.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;
  localparam int POS_W_DEF    = 11;

  typedef enum logic [1:0] {
    MODE_QUAD  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  // One bit per channel; the top widens each bit to the full channel width,
  // so "on" always means all ones in that channel.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t COL_WHITE   = 3'b111;
  localparam rgb_t COL_YELLOW  = 3'b110;
  localparam rgb_t COL_CYAN    = 3'b011;
  localparam rgb_t COL_GREEN   = 3'b010;
  localparam rgb_t COL_MAGENTA = 3'b101;
  localparam rgb_t COL_RED     = 3'b100;
  localparam rgb_t COL_BLUE    = 3'b001;
  localparam rgb_t COL_BLACK   = 3'b000;

  // Colour of bar idx, left to right.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: moves STEP pixels per axis once per frame and
// reverses direction on reaching either edge of the travel range.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int POS_W    = POS_W_DEF,
  parameter int BOX_SIZE = 64,
  parameter int STEP     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_end,
  output logic [POS_W-1:0] box_x,
  output logic [POS_W-1:0] box_y
);

  // One extra bit plus sign keeps pos-STEP and pos+STEP from wrapping.
  localparam logic signed [POS_W:0] STEP_S  = (POS_W+1)'(STEP);
  localparam logic signed [POS_W:0] X_LIM_S = (POS_W+1)'(H_ACTIVE - BOX_SIZE);
  localparam logic signed [POS_W:0] Y_LIM_S = (POS_W+1)'(V_ACTIVE - BOX_SIZE);

  logic                    dir_x;  // 1 = moving right
  logic                    dir_y;  // 1 = moving down
  logic signed [POS_W:0]   next_x;
  logic signed [POS_W:0]   next_y;

  // Candidate positions one step along the current direction.
  always_comb begin
    next_x = dir_x ? $signed({1'b0, box_x}) + STEP_S : $signed({1'b0, box_x}) - STEP_S;
    next_y = dir_y ? $signed({1'b0, box_y}) + STEP_S : $signed({1'b0, box_y}) - STEP_S;
  end

  // Per-frame update; reaching a limit clamps there and turns around.
  always_ff @(posedge clk) begin
    if (rst) begin
      box_x <= '0;
      box_y <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (frame_end) begin
      if (next_x >= X_LIM_S) begin
        box_x <= X_LIM_S[POS_W-1:0];
        dir_x <= 1'b0;
      end else if (next_x <= 0) begin
        box_x <= '0;
        dir_x <= 1'b1;
      end else begin
        box_x <= next_x[POS_W-1:0];
      end
      if (next_y >= Y_LIM_S) begin
        box_y <= Y_LIM_S[POS_W-1:0];
        dir_y <= 1'b0;
      end else if (next_y <= 0) begin
        box_y <= '0;
        dir_y <= 1'b1;
      end else begin
        box_y <= next_y[POS_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator between vga_sync and the RGB/sync pins.
// Stage 1 registers the raster inputs, stage 2 registers the colour computed
// from them, so colour, syncs and frame_tick all appear two cycles later.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int POS_W      = POS_W_DEF,
  parameter int R_W        = 3,
  parameter int G_W        = 2,
  parameter int B_W        = 3,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 64,
  parameter int STEP       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             display_en,
  input  logic [POS_W-1:0] x_pos,
  input  logic [POS_W-1:0] y_pos,
  input  logic             h_sync_in,
  input  logic             v_sync_in,
  input  logic [1:0]       mode_sel,
  output logic             h_sync,
  output logic             v_sync,
  output logic [R_W-1:0]   red,
  output logic [G_W-1:0]   green,
  output logic [B_W-1:0]   blue,
  output logic             frame_tick
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic             frame_start_in;
  logic             de_q;
  logic [POS_W-1:0] x_q;
  logic [POS_W-1:0] y_q;
  logic             hs_q;
  logic             vs_q;
  logic             tick_q;
  logic             end_q;
  mode_e            mode_r;
  logic [POS_W-1:0] box_x;
  logic [POS_W-1:0] box_y;
  logic [2:0]       bar_idx;
  logic             in_box;
  rgb_t             pix;

  assign frame_start_in = display_en && (x_pos == '0) && (y_pos == '0);

  // Stage 1: register raster inputs; adopt the requested mode at frame start
  // so the first pixel of the frame is already drawn in it.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      tick_q <= 1'b0;
      end_q  <= 1'b0;
      mode_r <= MODE_QUAD;
    end else begin
      de_q   <= display_en;
      x_q    <= x_pos;
      y_q    <= y_pos;
      hs_q   <= h_sync_in;
      vs_q   <= v_sync_in;
      tick_q <= frame_start_in;
      end_q  <= display_en && (x_pos == POS_W'(H_ACTIVE - 1)) && (y_pos == POS_W'(V_ACTIVE - 1));
      if (frame_start_in) mode_r <= mode_e'(mode_sel);
    end
  end

  // Box moves after the last pixel has been coloured with the old position.
  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .POS_W    (POS_W),
    .BOX_SIZE (BOX_SIZE),
    .STEP     (STEP)
  ) u_box_mover (
    .clk       (clk),
    .rst       (rst),
    .frame_end (end_q),
    .box_x     (box_x),
    .box_y     (box_y)
  );

  // Colour for the stage-1 pixel; bars located by threshold compares.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x_q >= POS_W'(i * BAR_W)) bar_idx = bar_idx + 3'd1;
    end
    in_box = (x_q >= box_x) && ({1'b0, x_q} < ({1'b0, box_x} + (POS_W+1)'(BOX_SIZE)))
          && (y_q >= box_y) && ({1'b0, y_q} < ({1'b0, box_y} + (POS_W+1)'(BOX_SIZE)));
    pix = COL_BLACK;
    if (de_q) begin
      case (mode_r)
        MODE_QUAD: begin
          if (y_q < POS_W'(V_ACTIVE / 2))
            pix = (x_q < POS_W'(H_ACTIVE / 2)) ? COL_RED : COL_BLUE;
          else
            pix = (x_q < POS_W'(H_ACTIVE / 2)) ? COL_GREEN : COL_WHITE;
        end
        MODE_BARS:  pix = bar_colour(bar_idx);
        MODE_CHECK: pix = (x_q[CHECK_LOG2] ^ y_q[CHECK_LOG2]) ? COL_WHITE : COL_BLACK;
        default:    pix = in_box ? COL_WHITE : COL_BLUE;
      endcase
    end
  end

  // Stage 2: output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      h_sync     <= 1'b0;
      v_sync     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      red        <= {R_W{pix.r}};
      green      <= {G_W{pix.g}};
      blue       <= {B_W{pix.b}};
      h_sync     <= hs_q;
      v_sync     <= vs_q;
      frame_tick <= tick_q;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: the driver predicts every cycle's
// output from a pixel-level reference model and queues it; a monitor pops
// and compares when each prediction falls due.
module tb_vga_pattern_gen;

  localparam int H = 800;
  localparam int V = 600;
  localparam int BOX = 64;
  localparam int LIM_X = H - BOX;
  localparam int LIM_Y = V - BOX;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        display_en = 1'b0;
  logic [10:0] x_pos = '0;
  logic [10:0] y_pos = '0;
  logic        h_sync_in = 1'b0;
  logic        v_sync_in = 1'b0;
  logic [1:0]  mode_sel = '0;
  logic        h_sync, v_sync, frame_tick;
  logic [2:0]  red;
  logic [1:0]  green;
  logic [2:0]  blue;

  vga_pattern_gen dut (
    .clk        (clk),
    .rst        (rst),
    .display_en (display_en),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .mode_sel   (mode_sel),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [10:0] val;   // {red, green, blue, h_sync, v_sync, frame_tick}
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: latched mode and number of box updates so far.
  int m_mode = 0;
  int m_upd  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Box position after n updates: a triangle wave between 0 and lim.
  function automatic int bounce(int n, int lim);
    int p;
    p = (n * 2) % (2 * lim);
    return (p <= lim) ? p : 2 * lim - p;
  endfunction

  // Pixel colour from the pattern rules, as {r_on, g_on, b_on}.
  function automatic logic [2:0] ref_rgb(int mode, int x, int y, int n);
    int bx, by, bar;
    bx = bounce(n, LIM_X);
    by = bounce(n, LIM_Y);
    case (mode)
      0: begin
        if (y < V / 2) return (x < H / 2) ? 3'b100 : 3'b001;
        else           return (x < H / 2) ? 3'b010 : 3'b111;
      end
      1: begin
        bar = x / (H / 8);
        case (bar)
          0: return 3'b111;
          1: return 3'b110;
          2: return 3'b011;
          3: return 3'b010;
          4: return 3'b101;
          5: return 3'b100;
          6: return 3'b001;
          default: return 3'b000;
        endcase
      end
      2: return (((x / 32) + (y / 32)) % 2 == 1) ? 3'b111 : 3'b000;
      default: return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 3'b111 : 3'b001;
    endcase
  endfunction

  // Apply one cycle of inputs and queue the output expected two cycles later.
  task automatic drv(input bit de, input int x, input int y, input int msel,
                     input string tag, input bit r = 1'b0);
    exp_t       e;
    logic [2:0] m;
    bit         hs, vs, fs;
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    rst        = r;
    display_en = de;
    x_pos      = 11'(x);
    y_pos      = 11'(y);
    h_sync_in  = hs;
    v_sync_in  = vs;
    mode_sel   = 2'(msel);
    e.due = cyc + 2;
    e.tag = tag;
    if (r) begin
      // Synchronous reset clears the output registers at the next edge too.
      foreach (exp_q[i]) if (exp_q[i].due == cyc + 1) exp_q[i].val = '0;
      m_mode = 0;
      m_upd  = 0;
      e.val  = '0;
    end else begin
      fs = de && x == 0 && y == 0;
      if (fs) m_mode = msel;
      m = de ? ref_rgb(m_mode, x, y, m_upd) : 3'b000;
      e.val = {{3{m[2]}}, {2{m[1]}}, {3{m[0]}}, hs, vs, fs};
      if (de && x == H - 1 && y == V - 1) m_upd++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_pixels(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0)
        drv(1'b0, $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 3), "blank");
      else
        drv(1'b1, $urandom_range(1, H - 1), $urandom_range(1, V - 2), $urandom_range(0, 3), tag);
    end
  endtask

  // Monitor: compare every prediction on the cycle it falls due.
  always @(negedge clk) begin
    exp_t  e;
    logic [10:0] act;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e   = exp_q.pop_front();
      act = {red, green, blue, h_sync, v_sync, frame_tick};
      checks++;
      if (e.due != cyc || act !== e.val) begin
        errors++;
        $display("FAIL %s cyc=%0d due=%0d got=%b exp=%b", e.tag, cyc, e.due, act, e.val);
      end
    end
  end

  initial begin
    int n;
    @(posedge clk);
    #1;
    repeat (3) drv(1'b0, 0, 0, 0, "reset", 1'b1);

    // Quadrants, including the midline seams, and blanking.
    drv(1'b1, 0, 0, 0, "quad_00_red");
    drv(1'b1, 400, 0, 1, "quad_400_0_blue");
    drv(1'b1, 399, 300, 2, "quad_399_300_green");
    drv(1'b1, 400, 300, 3, "quad_400_300_white");
    drv(1'b0, 400, 300, 1, "quad_blank");
    rnd_pixels(20, "quad_rand");
    drv(1'b1, H - 1, V - 1, 0, "quad_end");

    // Colour bars.
    drv(1'b1, 0, 0, 1, "bars_x0_white");
    drv(1'b1, 100, 5, 0, "bars_x100_yellow");
    drv(1'b1, 650, 5, 2, "bars_x650_blue");
    drv(1'b1, 799, 5, 3, "bars_x799_black");
    drv(1'b1, 99, 7, 3, "bars_x99_white");
    rnd_pixels(20, "bars_rand");
    drv(1'b1, H - 1, V - 1, 0, "bars_end");

    // Checkerboard.
    drv(1'b1, 0, 0, 2, "chk_00_black");
    drv(1'b1, 32, 0, 0, "chk_32_0_white");
    drv(1'b1, 32, 32, 1, "chk_32_32_black");
    drv(1'b1, 31, 32, 3, "chk_31_32_white");
    rnd_pixels(20, "chk_rand");
    drv(1'b1, H - 1, V - 1, 0, "chk_end");

    // Mid-frame mode request is held off until the next frame start.
    drv(1'b1, 0, 0, 0, "midsw_start_quad");
    drv(1'b1, 10, 10, 2, "midsw_10_10_quad");
    drv(1'b1, 450, 320, 2, "midsw_still_quad");
    rnd_pixels(10, "midsw_rand");
    drv(1'b1, H - 1, V - 1, 2, "midsw_end");
    drv(1'b1, 0, 0, 2, "midsw_next_chk");
    drv(1'b1, 32, 0, 2, "midsw_next_chk_white");
    drv(1'b1, H - 1, V - 1, 3, "midsw_end2");

    // Box frame, then reset in mid-line: back to mode 0 with box at origin.
    drv(1'b1, 0, 0, 3, "box_pre");
    drv(1'b1, 300, 200, 3, "box_pre_px");
    drv(1'b1, 301, 200, 3, "rst_mid", 1'b1);
    drv(1'b1, 10, 10, 3, "rst_after_quad_red");
    drv(1'b1, 500, 400, 3, "rst_after_quad_white");
    drv(1'b1, H - 1, V - 1, 3, "rst_after_end");
    drv(1'b0, 0, 0, 3, "reset2", 1'b1);

    // Bouncing box over enough frames to reach both clamps and turn back.
    for (int f = 0; f < 380; f++) begin
      int bx, by;
      bx = bounce(m_upd, LIM_X);
      by = bounce(m_upd, LIM_Y);
      drv(1'b1, 0, 0, 3, "box_start");
      drv(1'b1, bx, by, $urandom_range(0, 3), "box_corner");
      drv(1'b1, bx + BOX - 1, by, $urandom_range(0, 3), "box_right_in");
      if (bx + BOX < H) drv(1'b1, bx + BOX, by + 1, $urandom_range(0, 3), "box_right_out");
      if (bx > 0)       drv(1'b1, bx - 1, by + 1, $urandom_range(0, 3), "box_left_out");
      if (by + BOX < V) drv(1'b1, bx + 1, by + BOX, $urandom_range(0, 3), "box_below");
      rnd_pixels(2, "box_rand");
      drv(1'b1, H - 1, V - 1, 3, "box_end");
    end

    repeat (3) drv(1'b0, 0, 0, 0, "drain");
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
